lane_traffic_ctrl: RTL and testbench



---
 rtl/frogger_pkg.sv | 13 +
 rtl/lane_traffic_ctrl_lane_mover.sv | 52 +++++
 rtl/lane_traffic_ctrl.sv | 80 ++++++++
 tb/tb_lane_traffic_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared playfield constants and the lane direction encoding for the Frogger blocks.
package frogger_pkg;

  localparam int c_TILE_BITS   = 6;
  localparam int c_MAX_X_DEF   = 14;
  localparam int c_LANE_Y_BASE = 7;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage

// File: rtl/lane_traffic_ctrl_lane_mover.sv
// One obstacle lane: period counter with level-scaled terminal count, step and wrap.
module lane_mover
  import frogger_pkg::*;
#(
  parameter int unsigned               c_PERIOD = 4000000,
  parameter dir_e                      c_DIR    = DIR_RIGHT,
  parameter int                        c_MAX_X  = c_MAX_X_DEF,
  parameter logic [c_TILE_BITS-1:0]    c_INIT_X = '0
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Enable,
  input  logic                   i_Restart,
  input  logic [1:0]             i_Level,
  output logic [c_TILE_BITS-1:0] o_X
);

  localparam logic [c_TILE_BITS-1:0] c_LAST_X = c_TILE_BITS'(c_MAX_X - 1);

  logic [31:0]            period;
  logic [31:0]            count;
  logic                   terminal;
  logic [c_TILE_BITS-1:0] x_next;

  assign period = c_PERIOD >> i_Level;

  // >= rather than == so a period shortened mid-count terminates on the next clock.
  assign terminal = (period <= 32'd1) || (count >= period - 32'd1);

  always_comb begin
    x_next = o_X;
    if (c_DIR == DIR_LEFT)
      x_next = (o_X == '0) ? c_LAST_X : o_X - 1'b1;
    else
      x_next = (o_X == c_LAST_X) ? '0 : o_X + 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L || i_Restart) begin
      count <= '0;
      o_X   <= c_INIT_X;
    end else if (i_Enable) begin
      if (terminal) begin
        count <= '0;
        o_X   <= x_next;
      end else begin
        count <= count + 32'd1;
      end
    end
  end

endmodule

// File: rtl/lane_traffic_ctrl.sv
// Multi-lane obstacle controller: lane movers, collision edge detector and obstacle pixel flag.
module lane_traffic_ctrl
  import frogger_pkg::*;
#(
  parameter int                      c_NUM_LANES       = 5,
  parameter int                      c_FIRST_LANE_Y    = c_LANE_Y_BASE,
  parameter int                      c_MAX_X           = c_MAX_X_DEF,
  parameter int unsigned             c_BASE_SLOW_COUNT = 4000000,
  parameter int unsigned             c_LANE_STEP       = 300000,
  parameter logic [c_NUM_LANES-1:0]  c_DIR_MASK        = 5'b01010
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst_L,
  input  logic                               i_Enable,
  input  logic                               i_Restart,
  input  logic [1:0]                         i_Level,
  input  logic [4:0]                         i_Col_Count_Div,
  input  logic [4:0]                         i_Row_Count_Div,
  input  logic [5:0]                         i_Frogger_X,
  input  logic [5:0]                         i_Frogger_Y,
  output logic                               o_Obstacle_Pixel,
  output logic                               o_Collided,
  output logic [c_TILE_BITS*c_NUM_LANES-1:0] o_Car_X
);

  logic [c_TILE_BITS-1:0] car_x [c_NUM_LANES];
  logic                   overlap;
  logic                   overlap_hist;
  logic                   pixel_hit;

  for (genvar k = 0; k < c_NUM_LANES; k++) begin : g_lane
    localparam int unsigned c_PER  = c_BASE_SLOW_COUNT + k * c_LANE_STEP;
    localparam dir_e        c_DIRK = dir_e'(c_DIR_MASK[k]);
    localparam logic [c_TILE_BITS-1:0] c_INIT =
      (c_DIRK == DIR_LEFT) ? c_TILE_BITS'(c_MAX_X - 1) : '0;

    lane_mover #(
      .c_PERIOD (c_PER),
      .c_DIR    (c_DIRK),
      .c_MAX_X  (c_MAX_X),
      .c_INIT_X (c_INIT)
    ) u_lane (
      .i_Clk     (i_Clk),
      .i_Rst_L   (i_Rst_L),
      .i_Enable  (i_Enable),
      .i_Restart (i_Restart),
      .i_Level   (i_Level),
      .o_X       (car_x[k])
    );

    assign o_Car_X[c_TILE_BITS*k +: c_TILE_BITS] = car_x[k];
  end

  always_comb begin
    overlap   = 1'b0;
    pixel_hit = 1'b0;
    for (int k = 0; k < c_NUM_LANES; k++) begin
      if (car_x[k] == i_Frogger_X && c_TILE_BITS'(c_FIRST_LANE_Y + k) == i_Frogger_Y)
        overlap = 1'b1;
      if ({1'b0, i_Row_Count_Div} == c_TILE_BITS'(c_FIRST_LANE_Y + k) &&
          {1'b0, i_Col_Count_Div} == car_x[k])
        pixel_hit = 1'b1;
    end
  end

  // History only advances while enabled, so an overlap already present at resume still pulses.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L || i_Restart) begin
      overlap_hist     <= 1'b0;
      o_Collided       <= 1'b0;
      o_Obstacle_Pixel <= 1'b0;
    end else begin
      o_Obstacle_Pixel <= pixel_hit;
      o_Collided       <= i_Enable & overlap & ~overlap_hist;
      if (i_Enable)
        overlap_hist <= overlap;
    end
  end

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Bench for lane_traffic_ctrl: directed scenarios then random traffic against a lane-rule model.
module tb_lane_traffic_ctrl;

  localparam int NL    = 5;
  localparam int MAXX  = 14;
  localparam int BASE  = 4;
  localparam int STEP  = 2;
  localparam int Y0    = 7;
  localparam logic [NL-1:0] DMASK = 5'b01010;

  logic          i_Clk = 1'b0;
  logic          i_Rst_L, i_Enable, i_Restart;
  logic [1:0]    i_Level;
  logic [4:0]    i_Col_Count_Div, i_Row_Count_Div;
  logic [5:0]    i_Frogger_X, i_Frogger_Y;
  logic          o_Obstacle_Pixel, o_Collided;
  logic [6*NL-1:0] o_Car_X;

  int checks = 0;
  int failures = 0;

  // Model state: car positions, cycles elapsed in current lane period, collision history.
  int  mx [NL];
  int  mcnt [NL];
  bit  mhist;
  bit  exp_col, exp_pix;

  lane_traffic_ctrl #(
    .c_NUM_LANES(NL), .c_FIRST_LANE_Y(Y0), .c_MAX_X(MAXX),
    .c_BASE_SLOW_COUNT(BASE), .c_LANE_STEP(STEP), .c_DIR_MASK(DMASK)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Enable(i_Enable), .i_Restart(i_Restart),
    .i_Level(i_Level), .i_Col_Count_Div(i_Col_Count_Div), .i_Row_Count_Div(i_Row_Count_Div),
    .i_Frogger_X(i_Frogger_X), .i_Frogger_Y(i_Frogger_Y),
    .o_Obstacle_Pixel(o_Obstacle_Pixel), .o_Collided(o_Collided), .o_Car_X(o_Car_X)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic int init_x(int k);
    return DMASK[k] ? MAXX - 1 : 0;
  endfunction

  function automatic logic [6*NL-1:0] exp_cars();
    logic [6*NL-1:0] v;
    for (int k = 0; k < NL; k++) v[6*k +: 6] = 6'(mx[k]);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NL; k++) begin
      mx[k] = init_x(k);
      mcnt[k] = 0;
    end
    mhist = 0;
    exp_col = 0;
    exp_pix = 0;
  endtask

  // Advance the model by one clock edge using the inputs as they stand, then compare.
  task automatic cycle(input string tag);
    bit ov, pix;
    int per;
    ov = 0;
    pix = 0;
    for (int k = 0; k < NL; k++) begin
      if (mx[k] == int'(i_Frogger_X) && (Y0 + k) == int'(i_Frogger_Y)) ov = 1;
      if ((Y0 + k) == int'(i_Row_Count_Div) && mx[k] == int'(i_Col_Count_Div)) pix = 1;
    end
    if (!i_Rst_L || i_Restart) begin
      model_reset();
    end else begin
      exp_pix = pix;
      exp_col = i_Enable && ov && !mhist;
      if (i_Enable) begin
        mhist = ov;
        for (int k = 0; k < NL; k++) begin
          per = (BASE + k * STEP) >> i_Level;
          if (per < 1) per = 1;
          mcnt[k]++;
          if (mcnt[k] >= per) begin
            mcnt[k] = 0;
            mx[k] = DMASK[k] ? (mx[k] + MAXX - 1) % MAXX : (mx[k] + 1) % MAXX;
          end
        end
      end
    end
    @(posedge i_Clk);
    #1;
    checks += 3;
    assert (o_Car_X === exp_cars()) else begin
      failures++;
      $error("FAIL %s car_x observed=%h expected=%h", tag, o_Car_X, exp_cars());
    end
    assert (o_Collided === exp_col) else begin
      failures++;
      $error("FAIL %s collided observed=%b expected=%b", tag, o_Collided, exp_col);
    end
    assert (o_Obstacle_Pixel === exp_pix) else begin
      failures++;
      $error("FAIL %s pixel observed=%b expected=%b", tag, o_Obstacle_Pixel, exp_pix);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    logic [5:0] lane0_x;
    int guard;
    model_reset();
    i_Rst_L = 0; i_Enable = 1; i_Restart = 0; i_Level = 0;
    i_Col_Count_Div = 5'd1; i_Row_Count_Div = 5'd7;
    i_Frogger_X = 6'd20; i_Frogger_Y = 6'd0;

    // Reset held two clocks; all outputs at reset values.
    run(2, "reset");
    checks++;
    assert (o_Car_X === {6'd0, 6'd13, 6'd0, 6'd13, 6'd0}) else begin
      failures++;
      $error("FAIL reset_init observed=%h expected=%h", o_Car_X, {6'd0, 6'd13, 6'd0, 6'd13, 6'd0});
    end

    // Level 0: lane0 steps after 4 clocks, lane1 after 6.
    i_Rst_L = 1;
    run(4, "lvl0");
    checks++;
    assert (o_Car_X[5:0] === 6'd1) else begin
      failures++;
      $error("FAIL lane0_first_step observed=%0d expected=1", o_Car_X[5:0]);
    end
    run(2, "lvl0");
    checks++;
    assert (o_Car_X[11:6] === 6'd12) else begin
      failures++;
      $error("FAIL lane1_first_step observed=%0d expected=12", o_Car_X[11:6]);
    end
    run(10, "lvl0");

    // Level 2: lanes 0 and 1 step every clock and wrap.
    i_Level = 2;
    run(30, "wrap");

    // Pause mid-count at level 0, then resume.
    i_Level = 0;
    run(2, "prepause");
    i_Enable = 0;
    run(20, "pause");
    i_Enable = 1;
    run(12, "resume");

    // Collision: Frogger one tile ahead of lane0.
    i_Frogger_Y = 6'(Y0);
    i_Frogger_X = 6'((mx[0] + 1) % MAXX);
    run(14, "collide");
    i_Frogger_X = 6'(MAXX + 5);
    run(2, "clear");
    i_Enable = 0;
    i_Frogger_X = 6'(mx[0]);
    run(5, "col_paused");
    i_Enable = 1;
    run(3, "col_resume");

    // Restart with lane0 at X=9 on a terminal-count clock.
    i_Frogger_X = 6'd40;
    i_Level = 2;
    guard = 0;
    while (mx[0] != 9 && guard < 40) begin
      cycle("seek9");
      guard++;
    end
    checks++;
    assert (guard < 40) else begin
      failures++;
      $error("FAIL seek9_timeout observed=%0d expected<40", guard);
    end
    i_Restart = 1;
    cycle("restart");
    i_Restart = 0;
    checks++;
    assert (o_Car_X[5:0] === 6'd0) else begin
      failures++;
      $error("FAIL restart_x observed=%0d expected=0", o_Car_X[5:0]);
    end

    // Pixel flag on lane1 row, then an empty row.
    i_Level = 0;
    run(3, "prepix");
    i_Row_Count_Div = 5'd8;
    lane0_x = o_Car_X[11:6];
    i_Col_Count_Div = lane0_x[4:0];
    cycle("pix_hit");
    i_Row_Count_Div = 5'd6;
    cycle("pix_row6");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      i_Enable  = ($urandom_range(0, 9) != 0);
      i_Restart = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) i_Level = 2'($urandom_range(0, 3));
      i_Frogger_X = 6'($urandom_range(0, MAXX));
      i_Frogger_Y = 6'($urandom_range(Y0 - 1, Y0 + NL));
      i_Col_Count_Div = 5'($urandom_range(0, MAXX));
      i_Row_Count_Div = 5'($urandom_range(Y0 - 1, Y0 + NL));
      cycle("random");
    end
    i_Restart = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
